mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Shares one DATA_WIDTH-bit 2:1 word-mux datapath between two packet requesters, A and B.
//  - Packet-locked round-robin arbitration; the grant drives the mux select.
//  - One-entry registered output stage with a valid/ready handshake.
//  - Sits in front of any single-consumer datapath stage that two producers feed.
// PARAMETERS
//  DATA_WIDTH  32  word width of the A/B/out data paths
//  MAX_BEATS   16  longest legal packet in beats (>=1); a longer packet is cut with an error
// PORTS
//  clk          in   1           rising-edge clock
//  reset_n      in   1           asynchronous reset, active low
//  a_valid      in   1           A beat valid
//  a_last       in   1           A beat is the last of its packet
//  a_data       in   DATA_WIDTH  A beat data
//  a_ready      out  1           A beat accepted when a_valid & a_ready
//  b_valid/b_last/b_data/b_ready same as A, for requester B
//  out_valid    out  1           output register holds a beat
//  out_ready    in   1           consumer takes the beat when out_valid & out_ready
//  out_data     out  DATA_WIDTH  beat data
//  out_last     out  1           beat ends the packet (including a forced cut)
//  out_src      out  1           0 = beat came from A, 1 = from B
//  err_overlen  out  1           sticky: a packet exceeded MAX_BEATS; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state=IDLE; last_winner=1, so A wins the first tie.
//   - All outputs 0: out_*, a_ready, b_ready, err_overlen.
//   - beat_cnt=0. Reset mid-packet discards the packet and any held output beat.
//  FSM states: IDLE, OWN_A, OWN_B.
//  IDLE
//   - a_ready=b_ready=0.
//   - Only a_valid -> OWN_A; only b_valid -> OWN_B.
//   - Both -> the requester != last_winner. last_winner updates on entry.
//   - Grant is registered: the first beat is accepted one cycle after request at the earliest.
//  OWN_x
//   - x_ready = ~out_valid | out_ready. The other ready = 0.
//   - Mux select = (state==OWN_B); data is not registered before the mux.
//   - Grant holds while x_valid is low mid-packet. There is no timeout.
//  Accept (x_valid & x_ready)
//   - out_data <= x_data, out_src <= x, out_valid <= 1.
//   - out_last <= x_last | cut; beat_cnt increments.
//  Cut: beat_cnt==MAX_BEATS-1 on accept with x_last=0
//   - Set err_overlen; treat the beat as last.
//   - Later beats of that packet arrive as a new packet.
//  Packet end (accept with last or cut)
//   - beat_cnt <= 0.
//   - Other requester valid in the same cycle -> go directly to OWN_other, no bubble; else IDLE.
//  Output drain
//   - out_valid & out_ready with no new accept -> out_valid <= 0.
//   - out_data/out_last/out_src hold their values.
//   - While out_valid & ~out_ready, all output fields are stable.
//  Simultaneous accept and drain: the new beat replaces the old one; out_valid stays 1.
//   - Full throughput: 1 beat/clk.
//  beat_cnt width = clog2(MAX_BEATS+1); it never wraps.
// STRUCTURE
//  Shared package:
//   - state encoding localparams (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2)
//   - SRC_A=1'b0, SRC_B=1'b1
//  Sub-module arb_grant2 (combinational):
//   - Inputs: a_valid, b_valid, last_winner.
//   - Outputs: grant_valid, grant_b.
//   - Used from both IDLE and packet end.
//  Top level holds the FSM, beat counter and output register. The data mux is a per-bit and-or gate.
// TESTING
//  1 Assert reset_n=0 mid-traffic -> all outputs 0 at once; after release, A wins the first tie.
//  2 A and B both valid at the same cycle, 2-beat packets A=1,2 and B=3,4, out_ready=1
//    -> out_data 1,2,3,4; out_src 0,0,1,1; out_last 0,1,0,1.
//    -> no idle cycle between beats 2 and 3.
//  3 Backpressure
//    -> out_ready=0 for 3 clk with out_valid=1: a_ready=0 and out_data stable.
//    -> out_ready=1 -> next beat lands the following clk.
//  4 Both requesters continuously send 1-beat packets -> out_src alternates 0,1,0,1.
//  5 MAX_BEATS=4, A sends 6 beats with no last
//    -> beat 4 has out_last=1 and err_overlen=1.
//    -> grant goes to a waiting B before A's beats 5-6.
//  6 A drops a_valid for 5 clk mid-packet while B waits -> B is never granted until A's last beat.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the two-requester packet arbiter.
// Imported by the grant helper and the arbiter top level.
package mux_rr_arbiter_pkg;

    // Raw FSM state codes
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_OWN_A = OWN_A,
        ST_OWN_B = OWN_B
    } state_e;

    // Source tag carried with each output beat
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Owner state that a grant decision leads to
    function automatic state_e own_state(input logic grant_b);
        return grant_b ? ST_OWN_B : ST_OWN_A;
    endfunction

endpackage

// File: rtl/arb_grant2.sv
// Two-way round-robin grant decision.
// On a tie the requester that did not win last time is chosen.
module arb_grant2
    import mux_rr_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_winner,
    output logic grant_valid,
    output logic grant_b
);

    // Pick the winner among the presented requests
    always_comb begin
        grant_valid = a_valid | b_valid;
        grant_b     = 1'b0;
        unique case (1'b1)
            (a_valid & b_valid):  grant_b = (last_winner != SRC_B);
            (~a_valid & b_valid): grant_b = 1'b1;
            default:              grant_b = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one 2:1 word mux
// between requesters A and B, with a one-entry output register.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_valid,
    input  logic                  a_last,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic                  b_last,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_src,
    output logic                  err_overlen
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CUT_AT = CNT_W'(MAX_BEATS - 1);

    state_e                  state_q;
    logic                    last_winner_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [CNT_W-1:0]        beat_cnt_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_last_q;
    logic                    out_src_q;
    logic                    err_q;
    logic                    err_d;

    logic                    own_a;
    logic                    own_b;
    logic                    out_free;
    logic                    sel_b;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    mux_last;
    logic                    accept;
    logic                    cut;
    logic                    pkt_end;
    logic                    arb_a_req;
    logic                    arb_b_req;
    logic                    grant_valid;
    logic                    grant_b;

    // Handshake, and-or data mux, and packet boundary detection
    always_comb begin
        own_a    = (state_q == ST_OWN_A);
        own_b    = (state_q == ST_OWN_B);
        out_free = ~out_valid_q | out_ready;
        a_ready  = own_a & out_free;
        b_ready  = own_b & out_free;
        sel_b    = own_b;
        mux_data = ({DATA_WIDTH{~sel_b}} & a_data)
                 | ({DATA_WIDTH{sel_b}}  & b_data);
        mux_last = (~sel_b & a_last) | (sel_b & b_last);
        accept   = (a_valid & a_ready) | (b_valid & b_ready);
        cut      = accept & ~mux_last & (beat_cnt_q == CUT_AT);
        pkt_end  = accept & (mux_last | cut);
    end

    // Arbiter sees everyone in IDLE, only the other side at packet end
    always_comb begin
        arb_a_req = 1'b0;
        arb_b_req = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                arb_a_req = a_valid;
                arb_b_req = b_valid;
            end
            own_a: arb_b_req = pkt_end & b_valid;
            own_b: arb_a_req = pkt_end & a_valid;
            default: begin
                arb_a_req = 1'b0;
                arb_b_req = 1'b0;
            end
        endcase
    end

    arb_grant2 u_grant (
        .a_valid     (arb_a_req),
        .b_valid     (arb_b_req),
        .last_winner (last_winner_q),
        .grant_valid (grant_valid),
        .grant_b     (grant_b)
    );

    // Beat counter and sticky overlength flag next values
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pkt_end) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        err_d = err_q | cut;
    end

    // Ownership FSM with beat counter and error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_winner_q <= SRC_B;
            beat_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q       <= own_state(grant_b);
                        last_winner_q <= grant_b;
                    end
                end
                ST_OWN_A, ST_OWN_B: begin
                    if (pkt_end) begin
                        if (grant_valid) begin
                            state_q       <= own_state(grant_b);
                            last_winner_q <= grant_b;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output register: load on accept, empty on drain, else hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_last_q  <= mux_last | cut;
            out_src_q   <= sel_b ? SRC_B : SRC_A;
        end else if (out_valid_q & out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign out_src     = out_src_q;
    assign err_overlen = err_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter (MAX_BEATS=4).
// Requester drivers, output monitor and directed sequence.
module tb_mux_rr_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk;
    logic          reset_n;
    logic          a_valid, a_last, a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] b_data;
    logic          out_valid, out_ready, out_last, out_src;
    logic [DW-1:0] out_data;
    logic          err_overlen;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          s;
        logic          e;
    } exp_t;

    beat_t aq[$];
    beat_t bq[$];
    exp_t  expq[$];
    int    cons_cyc[$];
    int    cyc;
    int    checks;
    int    errors;

    mux_rr_arbiter #(
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .a_last      (a_last),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_last      (b_last),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .err_overlen (err_overlen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input int d, input logic l, input int gap);
        beat_t t;
        t.d = DW'(d);
        t.l = l;
        t.gap = gap;
        aq.push_back(t);
    endtask

    task automatic push_b(input int d, input logic l, input int gap);
        beat_t t;
        t.d = DW'(d);
        t.l = l;
        t.gap = gap;
        bq.push_back(t);
    endtask

    task automatic expect_beat(input int d, input logic l, input logic s,
                               input logic e);
        exp_t t;
        t.d = DW'(d);
        t.l = l;
        t.s = s;
        t.e = e;
        expq.push_back(t);
    endtask

    // Requester drivers: hold each beat until accepted
    initial begin
        logic  a_acc, b_acc;
        beat_t t;
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = '0;
        b_valid = 1'b0;
        b_last  = 1'b0;
        b_data  = '0;
        forever begin
            @(negedge clk);
            a_acc = a_valid & a_ready;
            b_acc = b_valid & b_ready;
            @(posedge clk);
            #1;
            if (a_acc && aq.size() > 0) void'(aq.pop_front());
            if (b_acc && bq.size() > 0) void'(bq.pop_front());
            a_valid = 1'b0;
            if (aq.size() > 0) begin
                t = aq[0];
                if (t.gap > 0) begin
                    t.gap = t.gap - 1;
                    aq[0] = t;
                end else begin
                    a_valid = 1'b1;
                    a_data  = t.d;
                    a_last  = t.l;
                end
            end
            b_valid = 1'b0;
            if (bq.size() > 0) begin
                t = bq[0];
                if (t.gap > 0) begin
                    t.gap = t.gap - 1;
                    bq[0] = t;
                end else begin
                    b_valid = 1'b1;
                    b_data  = t.d;
                    b_last  = t.l;
                end
            end
        end
    end

    // Output monitor: compare each consumed beat with the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                cons_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    check("beat_unexpected", {28'd0, err_overlen, out_src,
                          out_last, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("beat", {29'd0, err_overlen, out_src, out_last,
                          out_data}, {29'd0, e.e, e.s, e.l, e.d});
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || aq.size() != 0 || bq.size() != 0)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 64'(expq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic gap_check(input string name, input int i);
        if (cons_cyc.size() > i)
            check(name, 64'(cons_cyc[i] - cons_cyc[i-1]), 64'd1);
        else
            check(name, 64'(cons_cyc.size()), 64'(i + 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_out_src"}, 64'(out_src), 64'd0);
        check({tag, "_a_ready"}, 64'(a_ready), 64'd0);
        check({tag, "_b_ready"}, 64'(b_ready), 64'd0);
        check({tag, "_err"}, 64'(err_overlen), 64'd0);
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        #3;
        check_all_zero("rst0");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Simultaneous 2-beat packets: A wins, B follows without a bubble
        @(posedge clk);
        #2;
        cons_cyc.delete();
        push_a(1, 1'b0, 0);
        push_a(2, 1'b1, 0);
        push_b(3, 1'b0, 0);
        push_b(4, 1'b1, 0);
        expect_beat(1, 1'b0, 1'b0, 1'b0);
        expect_beat(2, 1'b1, 1'b0, 1'b0);
        expect_beat(3, 1'b0, 1'b1, 1'b0);
        expect_beat(4, 1'b1, 1'b1, 1'b0);
        drain("pair");
        gap_check("pair_nobubble", 2);

        // Continuous 1-beat packets alternate A,B at full rate
        @(posedge clk);
        #2;
        cons_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            push_a(20 + i, 1'b1, 0);
            push_b(30 + i, 1'b1, 0);
            expect_beat(20 + i, 1'b1, 1'b0, 1'b0);
            expect_beat(30 + i, 1'b1, 1'b1, 1'b0);
        end
        drain("alt");
        for (int i = 1; i < 6; i++) gap_check("alt_rate", i);

        // Backpressure: output held, A stalled, then next beat next clk
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        push_a(10, 1'b0, 0);
        push_a(11, 1'b1, 0);
        expect_beat(10, 1'b0, 1'b0, 1'b0);
        expect_beat(11, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_fill", 64'(out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_a_ready", 64'(a_ready), 64'd0);
            check("bp_data_hold", 64'(out_data), 64'd10);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_data", 64'(out_data), 64'd11);
        drain("bp");

        // A pauses mid-packet while B waits: B only after A's last
        @(posedge clk);
        #2;
        push_a(40, 1'b0, 0);
        push_a(41, 1'b0, 5);
        push_a(42, 1'b1, 0);
        expect_beat(40, 1'b0, 1'b0, 1'b0);
        expect_beat(41, 1'b0, 1'b0, 1'b0);
        expect_beat(42, 1'b1, 1'b0, 1'b0);
        expect_beat(50, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 push_b(50, 1'b1, 0);
        drain("hold");

        // Overlength: 4th beat cut, B served before A's beats 5-6
        check("err_before", 64'(err_overlen), 64'd0);
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) push_a(60 + i, 1'b0, 0);
        expect_beat(60, 1'b0, 1'b0, 1'b0);
        expect_beat(61, 1'b0, 1'b0, 1'b0);
        expect_beat(62, 1'b0, 1'b0, 1'b0);
        expect_beat(63, 1'b1, 1'b0, 1'b1);
        expect_beat(70, 1'b1, 1'b1, 1'b1);
        expect_beat(64, 1'b0, 1'b0, 1'b1);
        expect_beat(65, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2 push_b(70, 1'b1, 0);
        drain("cut");
        check("err_sticky", 64'(err_overlen), 64'd1);

        // Reset mid-packet with a held output beat
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        push_a(80, 1'b0, 0);
        push_a(81, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        check("rst_pre_data", 64'(out_data), 64'd80);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        aq.delete();
        bq.delete();
        expq.delete();
        repeat (3) @(posedge clk);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // First tie after reset goes to A
        @(posedge clk);
        #2;
        push_a(90, 1'b1, 0);
        push_b(91, 1'b1, 0);
        expect_beat(90, 1'b1, 1'b0, 1'b0);
        expect_beat(91, 1'b1, 1'b1, 1'b0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
